cop_sequencer: RTL and testbench
================================

# cop_sequencer

Multi-cycle issue controller for the floating-point coprocessor. It sits between the instruction decoder and the coprocessor datapath. It accepts one decoded coprocessor instruction at a time, issues a start pulse, and stalls the PC until the coprocessor reports completion. It then either writes the result back to the register file or raises a trap, depending on the returned exception flags and the trap mask. It also keeps a sticky exception status register visible to software.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: WAIT-state watchdog limit. Used only when `COP_TIMEOUT_EN` is defined. Valid range 2..255.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `cop_req` in 1: a decoded coprocessor instruction is valid this cycle.
- `cop_opcode` in 5: coprocessor opcode (instruction[30:26]).
- `cop_dst` in 5: destination register (instruction[25:21]).
- `cop_start` out 1: one-cycle start pulse to the coprocessor.
- `cop_op` out 5: registered opcode, stable from ISSUE through WAIT.
- `cop_done` in 1: coprocessor result-valid pulse.
- `coP_NaN_flag`, `coP_UF_flag`, `coP_OF_flag`, `coP_Division_by_zero_flag` in 1 each: sampled only when `cop_done` is high.
- `trap_mask` in 4: per-flag trap enable. Bit order is {DivZero, OF, UF, NaN}.
- `status_clear` in 1: clears the sticky status register.
- `pc_stall` out 1: PC hold. The PC enable is driven as the inverse of this signal.
- `busy` out 1: high whenever the state is not IDLE.
- `reg_write_enable` out 1: one-cycle write-back pulse.
- `reg_write_addr` out 5: write-back register address.
- `status_flags` out 5: sticky flags. Bits [3:0] follow `trap_mask` order; bit 4 is timeout.
- `trap` out 1: one-cycle exception pulse.

## Operation
The controller is a five-state FSM: IDLE, ISSUE, WAIT, WB, TRAP.

- **IDLE**
  - On `cop_req`, latch `cop_opcode` into `cop_op` and `cop_dst` into `reg_write_addr`, then go to ISSUE.
  - `cop_req` in any other state is ignored. The stall prevents the decoder from presenting a new instruction.
- **ISSUE**
  - `cop_start` = 1 for this cycle only. Next state is WAIT.
- **WAIT**
  - `cop_done` is honoured only in this state.
  - On `cop_done`, latch the four flags as F and OR them into `status_flags[3:0]`.
  - If (F & `trap_mask`) != 0, go to TRAP; otherwise go to WB.
- **WB**
  - `reg_write_enable` = 1 for this cycle. Next state is IDLE.
- **TRAP**
  - `trap` = 1 for this cycle. No register write. Next state is IDLE.

Outputs:
- `pc_stall` = `cop_req` & (state == IDLE), OR (state != IDLE). This is combinational, so the PC holds in the request cycle itself.
- `cop_start`, `reg_write_enable`, `trap` and `busy` are decoded from the registered state. They have no combinational path from inputs.

Status register:
- `status_clear` zeroes `status_flags`.
- If a flag capture or timeout happens in the same cycle as `status_clear`, the set wins for those bits; all other bits clear.

Reset values (from `rst`):
- state = IDLE.
- `cop_op`, `reg_write_addr`, `status_flags` and the watchdog counter are all zero.
- All pulse outputs and `busy` are 0.
- `pc_stall` is 0 unless `cop_req` is high.

## Timing
- The request is accepted at edge 0.
  - Cycle 1: ISSUE (`cop_start` high).
  - Cycle 2 onward: WAIT.
- If `cop_done` is sampled in WAIT cycle k, the next cycle is WB or TRAP, and the cycle after that is IDLE.
- Minimum request-to-IDLE latency is 4 cycles, with `cop_done` high in the first WAIT cycle. `pc_stall` is high for exactly those 4 cycles.
- `cop_done` asserted during ISSUE or IDLE is discarded, along with its flags.
- `rst` asserted mid-operation aborts at the next edge:
  - No write-back and no trap.
  - A pending `cop_start` is not issued.
- Back-to-back requests: a new `cop_req` may be accepted in the IDLE cycle that directly follows WB or TRAP.

## Configuration
`COP_TIMEOUT_EN`:
- **Defined:** an 8-bit counter clears on entry to WAIT and increments each WAIT cycle without `cop_done`.
  - When the count reaches `TIMEOUT_CYCLES`, set `status_flags[4]` and go to TRAP, regardless of `trap_mask`.
  - If `cop_done` arrives on the same cycle the limit is reached, `cop_done` wins and no timeout is recorded.
- **Undefined:** WAIT waits indefinitely, `status_flags[4]` is tied to 0, and the counter is not synthesized.

## Test plan
- **Normal completion:** `cop_req` with opcode 5'b10011 and dst 7; `cop_done` in the first WAIT cycle with all flags 0.
  - `cop_start` pulses in cycle 1.
  - WB occurs in cycle 3 with `reg_write_enable`=1 and addr=7.
  - `pc_stall` is high for cycles 0-3; `trap` stays 0.
- **Masked flag:** `trap_mask`=4'b0100; `cop_done` with OF=1, 5 cycles after start.
  - `trap` pulses once with no write.
  - `status_flags`=5'b00100.
- **Unmasked flag:** `trap_mask`=0; `cop_done` with NaN=1 and UF=1.
  - WB write occurs.
  - `status_flags`=5'b00011, held until `status_clear`; `status_clear` then gives 0.
- **Clear/set collision:** `status_clear` in the same cycle as a `cop_done` with DivZero=1 → `status_flags`=5'b01000.
- **Reset and ignored done:**
  - `rst` during WAIT → IDLE next cycle, all outputs 0, no write or trap.
  - `cop_done` pulsed during ISSUE is ignored, and the FSM remains in WAIT.
- **Timeout (`COP_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** no `cop_done` → after 8 WAIT cycles, `trap` pulses and `status_flags[4]`=1. Without the macro, the FSM stays in WAIT for 1000 cycles.

Source files
------------

// File: rtl/cop_if.sv
// Decoder/coprocessor-side signal bundle for cop_sequencer.
// master = decoder/coprocessor environment, slave = the sequencer itself.
interface cop_if;
  logic       cop_req;
  logic [4:0] cop_opcode;
  logic [4:0] cop_dst;
  logic       cop_start;
  logic [4:0] cop_op;
  logic       cop_done;
  logic       coP_NaN_flag;
  logic       coP_UF_flag;
  logic       coP_OF_flag;
  logic       coP_Division_by_zero_flag;
  logic [3:0] trap_mask;
  logic       status_clear;
  logic       pc_stall;
  logic       busy;
  logic       reg_write_enable;
  logic [4:0] reg_write_addr;
  logic [4:0] status_flags;
  logic       trap;

  modport master (
    output cop_req, cop_opcode, cop_dst, cop_done,
           coP_NaN_flag, coP_UF_flag, coP_OF_flag, coP_Division_by_zero_flag,
           trap_mask, status_clear,
    input  cop_start, cop_op, pc_stall, busy, reg_write_enable,
           reg_write_addr, status_flags, trap
  );

  modport slave (
    input  cop_req, cop_opcode, cop_dst, cop_done,
           coP_NaN_flag, coP_UF_flag, coP_OF_flag, coP_Division_by_zero_flag,
           trap_mask, status_clear,
    output cop_start, cop_op, pc_stall, busy, reg_write_enable,
           reg_write_addr, status_flags, trap
  );
endinterface

// File: rtl/cop_sequencer.sv
// Multi-cycle issue controller for the FP coprocessor: issue, stall, write back or trap.
// Optional WAIT watchdog enabled by defining COP_TIMEOUT_EN.
module cop_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  cop_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_TRAP
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       start;
  logic       wb;
  logic       trap_out;
  logic       busy_out;
  logic       capture;
  logic       limit_hit;
  logic [3:0] flags;
  logic [4:0] status;
  logic [4:0] status_nxt;
  logic [4:0] op_q;
  logic [4:0] addr_q;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("cop_sequencer: TIMEOUT_CYCLES must be in 2..255");
  end

  assign flags = {bus.coP_Division_by_zero_flag, bus.coP_OF_flag,
                  bus.coP_UF_flag, bus.coP_NaN_flag};

`ifdef COP_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_cnt;

  // Limit is judged on the count this WAIT cycle would reach; done takes priority.
  assign limit_hit = (state == S_WAIT) && !bus.cop_done && (wait_cnt + 8'd1 == LIMIT);

  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= 8'd0;
    else if (state == S_ISSUE)
      wait_cnt <= 8'd0;
    else if (state == S_WAIT && !bus.cop_done)
      wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    wb        = 1'b0;
    trap_out  = 1'b0;
    busy_out  = 1'b1;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        busy_out = 1'b0;
        if (bus.cop_req)
          state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        start     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.cop_done) begin
          capture   = 1'b1;
          state_nxt = |(flags & bus.trap_mask) ? S_TRAP : S_WB;
        end else if (limit_hit) begin
          state_nxt = S_TRAP;
        end
      end
      S_WB: begin
        wb        = 1'b1;
        state_nxt = S_IDLE;
      end
      S_TRAP: begin
        trap_out  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bits being set this cycle survive a simultaneous clear.
  always_comb begin
    status_nxt = bus.status_clear ? 5'b0 : status;
    status_nxt = status_nxt | {limit_hit, (capture ? flags : 4'b0)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= 5'd0;
      addr_q <= 5'd0;
      status <= 5'd0;
    end else begin
      if (state == S_IDLE && bus.cop_req) begin
        op_q   <= bus.cop_opcode;
        addr_q <= bus.cop_dst;
      end
      status <= status_nxt;
    end
  end

  assign bus.cop_start        = start;
  assign bus.cop_op           = op_q;
  assign bus.busy             = busy_out;
  assign bus.reg_write_enable = wb;
  assign bus.reg_write_addr   = addr_q;
  assign bus.trap             = trap_out;
  assign bus.status_flags     = status;
  assign bus.pc_stall         = bus.cop_req | (state != S_IDLE);

endmodule

// File: tb/tb_cop_sequencer.sv
// Directed bench for cop_sequencer with a transaction-timeline reference model.
module tb_cop_sequencer;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cop_if bus ();

  cop_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: s = cycles since acceptance (-1 idle), done_at = value of s when the
  // transaction resolved in WAIT, end cycle is done_at+1.
  int         s       = -1;
  int         done_at = -1;
  bit         m_trap  = 1'b0;
  bit         model_ok = 1'b0;
  logic [4:0] m_op = '0, m_addr = '0, m_status = '0, set_bits;
  logic [3:0] f;
  logic       e_busy, e_start, e_end;

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      e_busy  = (s >= 1);
      e_start = (s == 1);
      e_end   = (s >= 1) && (done_at >= 0) && (s == done_at + 1);
      chk("busy",             32'(bus.busy),             32'(e_busy));
      chk("cop_start",        32'(bus.cop_start),        32'(e_start));
      chk("reg_write_enable", 32'(bus.reg_write_enable), 32'(e_end && !m_trap));
      chk("trap",             32'(bus.trap),             32'(e_end && m_trap));
      chk("pc_stall",         32'(bus.pc_stall),         32'(e_busy | bus.cop_req));
      chk("cop_op",           32'(bus.cop_op),           32'(m_op));
      chk("reg_write_addr",   32'(bus.reg_write_addr),   32'(m_addr));
      chk("status_flags",     32'(bus.status_flags),     32'(m_status));
    end
    if (rst) begin
      s = -1; done_at = -1; m_trap = 1'b0;
      m_op = '0; m_addr = '0; m_status = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      set_bits = '0;
      if (s == -1) begin
        if (bus.cop_req) begin
          s = 1; m_op = bus.cop_opcode; m_addr = bus.cop_dst;
        end
      end else begin
        if (s >= 2 && done_at < 0) begin
          if (bus.cop_done) begin
            f = {bus.coP_Division_by_zero_flag, bus.coP_OF_flag, bus.coP_UF_flag, bus.coP_NaN_flag};
            set_bits[3:0] = f;
            done_at = s;
            m_trap = |(f & bus.trap_mask);
          end
`ifdef COP_TIMEOUT_EN
          else if (s - 1 == TO) begin
            set_bits[4] = 1'b1;
            done_at = s;
            m_trap = 1'b1;
          end
`endif
        end
        if (done_at >= 0 && s == done_at + 1) begin
          s = -1; done_at = -1;
        end else begin
          s++;
        end
      end
      m_status = (bus.status_clear ? 5'b0 : m_status) | set_bits;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] fl);
    {bus.coP_Division_by_zero_flag, bus.coP_OF_flag, bus.coP_UF_flag, bus.coP_NaN_flag} = fl;
  endtask

  // Ends inside the WB/TRAP cycle of the transaction.
  task automatic txn(input logic [4:0] opc, input logic [4:0] dst, input logic [3:0] fl,
                     input int waits, input bit clr);
    tick(); bus.cop_req = 1'b1; bus.cop_opcode = opc; bus.cop_dst = dst;
    tick(); bus.cop_req = 1'b0;
    repeat (waits) tick();
    tick(); bus.cop_done = 1'b1; set_flags(fl); bus.status_clear = clr;
    tick(); bus.cop_done = 1'b0; set_flags(4'b0); bus.status_clear = 1'b0;
  endtask

  initial begin
    bus.cop_req = 1'b0; bus.cop_opcode = '0; bus.cop_dst = '0;
    bus.cop_done = 1'b0; set_flags(4'b0);
    bus.trap_mask = 4'b0; bus.status_clear = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_status", 32'(bus.status_flags), 32'd0);
    chk("rst_cop_op", 32'(bus.cop_op), 32'd0);
    chk("rst_pc_stall", 32'(bus.pc_stall), 32'd0);

    // Normal completion
    tick(); bus.cop_req = 1'b1; bus.cop_opcode = 5'b10011; bus.cop_dst = 5'd7;
    @(negedge clk); chk("t1_stall_c0", 32'(bus.pc_stall), 32'd1);
    tick(); bus.cop_req = 1'b0;
    @(negedge clk); chk("t1_start_c1", 32'(bus.cop_start), 32'd1);
    tick(); bus.cop_done = 1'b1;
    @(negedge clk); chk("t1_stall_c2", 32'(bus.pc_stall), 32'd1);
    tick(); bus.cop_done = 1'b0;
    @(negedge clk);
    chk("t1_wbe_c3", 32'(bus.reg_write_enable), 32'd1);
    chk("t1_addr_c3", 32'(bus.reg_write_addr), 32'd7);
    chk("t1_op_c3", 32'(bus.cop_op), 32'h13);
    tick();
    @(negedge clk); chk("t1_stall_c4", 32'(bus.pc_stall), 32'd0);

    // Masked OF flag -> trap
    bus.trap_mask = 4'b0100;
    txn(5'd1, 5'd3, 4'b0100, 4, 1'b0);
    @(negedge clk);
    chk("t2_trap", 32'(bus.trap), 32'd1);
    chk("t2_wbe", 32'(bus.reg_write_enable), 32'd0);
    tick();
    @(negedge clk); chk("t2_status", 32'(bus.status_flags), 32'h04);
    tick(); bus.status_clear = 1'b1;
    tick(); bus.status_clear = 1'b0;
    @(negedge clk); chk("t2_cleared", 32'(bus.status_flags), 32'h00);

    // Unmasked NaN+UF -> write back, sticky until cleared
    bus.trap_mask = 4'b0000;
    txn(5'd2, 5'd9, 4'b0011, 0, 1'b0);
    @(negedge clk);
    chk("t3_wbe", 32'(bus.reg_write_enable), 32'd1);
    chk("t3_addr", 32'(bus.reg_write_addr), 32'd9);
    repeat (3) tick();
    @(negedge clk); chk("t3_status", 32'(bus.status_flags), 32'h03);
    tick(); bus.status_clear = 1'b1;
    tick(); bus.status_clear = 1'b0;
    @(negedge clk); chk("t3_cleared", 32'(bus.status_flags), 32'h00);

    // Clear/set collision
    txn(5'd4, 5'd1, 4'b0100, 0, 1'b0);
    tick();
    @(negedge clk); chk("t4_pre", 32'(bus.status_flags), 32'h04);
    txn(5'd5, 5'd2, 4'b1000, 1, 1'b1);
    @(negedge clk);
    chk("t4_collide", 32'(bus.status_flags), 32'h08);
    chk("t4_wbe", 32'(bus.reg_write_enable), 32'd1);

    // Done during ISSUE ignored, then reset in WAIT
    bus.trap_mask = 4'b1111;
    tick(); bus.cop_req = 1'b1; bus.cop_opcode = 5'd6; bus.cop_dst = 5'd4;
    tick(); bus.cop_req = 1'b0; bus.cop_done = 1'b1; set_flags(4'b0001);
    tick(); bus.cop_done = 1'b0; set_flags(4'b0);
    repeat (3) tick();
    @(negedge clk);
    chk("t5_still_busy", 32'(bus.busy), 32'd1);
    chk("t5_status_kept", 32'(bus.status_flags), 32'h08);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_trap", 32'(bus.trap), 32'd0);
    chk("t5_rst_wbe", 32'(bus.reg_write_enable), 32'd0);
    chk("t5_rst_op", 32'(bus.cop_op), 32'd0);
    chk("t5_rst_status", 32'(bus.status_flags), 32'd0);

    // Back-to-back acceptance right after WB
    bus.trap_mask = 4'b0000;
    txn(5'd7, 5'd10, 4'b0000, 0, 1'b0);
    tick(); bus.cop_req = 1'b1; bus.cop_opcode = 5'd8; bus.cop_dst = 5'd11;
    tick(); bus.cop_req = 1'b0;
    @(negedge clk);
    chk("t6_start", 32'(bus.cop_start), 32'd1);
    chk("t6_op", 32'(bus.cop_op), 32'd8);
    tick(); bus.cop_done = 1'b1;
    tick(); bus.cop_done = 1'b0;
    @(negedge clk); chk("t6_addr", 32'(bus.reg_write_addr), 32'd11);

    // Watchdog
    tick(); bus.cop_req = 1'b1; bus.cop_opcode = 5'd9; bus.cop_dst = 5'd12;
    tick(); bus.cop_req = 1'b0;
`ifdef COP_TIMEOUT_EN
    repeat (TO) tick();
    tick();
    @(negedge clk);
    chk("t7_trap", 32'(bus.trap), 32'd1);
    chk("t7_status", 32'(bus.status_flags), 32'h10);
    tick();
    @(negedge clk); chk("t7_idle", 32'(bus.busy), 32'd0);
`else
    repeat (1000) tick();
    @(negedge clk);
    chk("t7_waiting", 32'(bus.busy), 32'd1);
    chk("t7_status", 32'(bus.status_flags), 32'h00);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
`endif
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
